bin2bcd_seq: RTL and testbench

- Iterative binary-to-BCD converter directly upstream of the two-digit seven-segment decoder.
- Takes a 9-bit two's-complement calculator result, computes magnitude and sign, and runs a shift-add-3 (double dabble) loop, one bit per cycle.
- Presents a registered, saturated two-digit BCD word {ovf, tens, ones} plus sign bit, in the exact format the decoder consumes.

---
 rtl/bin2bcd_seq_pkg.sv | 38 +++
 rtl/bin2bcd_seq_bcd_add3.sv | 17 +
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 tb/tb_bin2bcd_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter.
//   state_t         : controller states (IDLE, SHIFT, DONE)
//   DATA_W / NDIG   : operand width / internal BCD digit count
//   bcd_out fields  : overflow flag, tens digit, ones digit positions
//   abs_mag()       : magnitude of a two's-complement operand
package bin2bcd_seq_pkg;

    localparam int DATA_W = 9;
    localparam int NDIG   = 3;
    localparam int BCD_W  = NDIG * 4;
    localparam int CNT_W  = 4;

    localparam logic [3:0]       BCD_NINE  = 4'd9;
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(DATA_W - 1);

    localparam int OVF_BIT  = 8;
    localparam int TENS_MSB = 7;
    localparam int TENS_LSB = 4;
    localparam int ONES_MSB = 3;
    localparam int ONES_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The unsigned reading of the result is the magnitude. For the most
    // negative operand (-256) the two's complement wraps back onto
    // 1_0000_0000, which read as unsigned is exactly 256, so DATA_W bits
    // are enough and no extra width is needed.
    function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] one;
        one = {{(DATA_W-1){1'b0}}, 1'b1};
        return v[DATA_W-1] ? (~v) + one : v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
//   digit_in  : 4-bit BCD digit before correction
//   digit_out : corrected digit
module bin2bcd_seq_bcd_add3 (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter feeding the two-digit 7-segment decoder.
// Converts a 9-bit two's-complement operand one bit per clock and presents
// a saturated {ovf, tens, ones} word plus sign.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   SHIFT | one double-dabble iteration per clock, DATA_W iterations
//   DONE  | outputs just loaded, done pulse high for this cycle
//
// Ports:
//   clk      : system clock, rising edge
//   nrst     : asynchronous active-low reset
//   start    : conversion request, sampled only in IDLE
//   value    : two's-complement operand, captured on the accepting edge
//   busy     : high whenever not IDLE
//   done     : one-cycle pulse, bcd_out/sign_out just updated
//   bcd_out  : [8]=overflow (>99), [7:4]=tens, [3:0]=ones
//   sign_out : operand was negative
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              done,
    output logic [8:0]        bcd_out,
    output logic              sign_out
);

    state_t                    state;
    logic [BCD_W-1:0]          bcd;
    logic [BCD_W-1:0]          bcd_adj;
    logic [DATA_W-1:0]         mag;
    logic [CNT_W-1:0]          cnt;
    logic                      neg;
    logic [BCD_W+DATA_W-1:0]   shift_nxt;
    logic [BCD_W-1:0]          bcd_nxt;
    logic [8:0]                result;

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bin2bcd_seq_bcd_add3 u_add3 (
            .digit_in  (bcd[g*4 +: 4]),
            .digit_out (bcd_adj[g*4 +: 4])
        );
    end

    // The corrected digits and the remaining magnitude bits shift as one word.
    always_comb begin
        shift_nxt = {bcd_adj, mag} << 1;
        bcd_nxt   = shift_nxt[BCD_W+DATA_W-1:DATA_W];
    end

    // Final word is built from the last iteration's shift so that the
    // outputs load on the same edge that completes the conversion.
    always_comb begin
        result = '0;
        if (bcd_nxt[11:8] != 4'd0) begin
            result[OVF_BIT]           = 1'b1;
            result[TENS_MSB:TENS_LSB] = BCD_NINE;
            result[ONES_MSB:ONES_LSB] = BCD_NINE;
        end else begin
            result[OVF_BIT]           = 1'b0;
            result[TENS_MSB:TENS_LSB] = bcd_nxt[7:4];
            result[ONES_MSB:ONES_LSB] = bcd_nxt[3:0];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            sign_out <= 1'b0;
            bcd      <= '0;
            mag      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag   <= abs_mag(value);
                        neg   <= value[DATA_W-1];
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= bcd_nxt;
                    mag <= shift_nxt[DATA_W-1:0];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == ITER_LAST) begin
                        bcd_out  <= result;
                        sign_out <= neg;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic       clk;
    logic       nrst;
    logic       start;
    logic [8:0] value;
    logic       busy;
    logic       done;
    logic [8:0] bcd_out;
    logic       sign_out;

    int errors = 0;
    int checks = 0;

    logic [8:0] last_bcd  = 9'h000;
    logic       last_sign = 1'b0;

    bin2bcd_seq dut (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .sign_out (sign_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full conversion from IDLE: start sampled at the next edge (N), done
    // expected after edge N+9, back in IDLE after edge N+10.
    task automatic run(input string tag, input logic [8:0] v,
                       input logic [8:0] exp_bcd, input logic exp_sign);
        start = 1'b1;
        value = v;
        tick();
        start = 1'b0;
        value = 9'h0AA;
        chk({tag, " busy@N"}, {8'b0, busy}, 9'd1);
        chk({tag, " done@N"}, {8'b0, done}, 9'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk({tag, " done in shift"}, {8'b0, done}, 9'd0);
            chk({tag, " busy in shift"}, {8'b0, busy}, 9'd1);
            chk({tag, " hold bcd"}, bcd_out, last_bcd);
            chk({tag, " hold sign"}, {8'b0, sign_out}, {8'b0, last_sign});
        end
        tick();
        chk({tag, " done@N+9"}, {8'b0, done}, 9'd1);
        chk({tag, " busy@N+9"}, {8'b0, busy}, 9'd1);
        chk({tag, " bcd"}, bcd_out, exp_bcd);
        chk({tag, " sign"}, {8'b0, sign_out}, {8'b0, exp_sign});
        tick();
        chk({tag, " done@N+10"}, {8'b0, done}, 9'd0);
        chk({tag, " busy@N+10"}, {8'b0, busy}, 9'd0);
        chk({tag, " bcd held"}, bcd_out, exp_bcd);
        last_bcd  = exp_bcd;
        last_sign = exp_sign;
    endtask

    initial begin
        nrst  = 1'b0;
        start = 1'b0;
        value = 9'h000;
        #3;
        chk("reset busy", {8'b0, busy}, 9'd0);
        chk("reset done", {8'b0, done}, 9'd0);
        chk("reset bcd", bcd_out, 9'h000);
        chk("reset sign", {8'b0, sign_out}, 9'd0);
        tick();
        tick();
        nrst = 1'b1;
        tick();
        chk("idle busy", {8'b0, busy}, 9'd0);

        run("v45", 9'd45, 9'h045, 1'b0);
        run("vm37", 9'h1DB, 9'h037, 1'b1);
        run("v0", 9'd0, 9'h000, 1'b0);
        run("v99", 9'd99, 9'h099, 1'b0);
        run("v100", 9'd100, 9'h199, 1'b0);
        run("v255", 9'd255, 9'h199, 1'b0);
        run("vm256", 9'h100, 9'h199, 1'b1);
        run("v1", 9'd1, 9'h001, 1'b0);

        // start while busy is ignored; held start is taken once IDLE again
        start = 1'b1;
        value = 9'd45;
        tick();                                  // edge N
        start = 1'b0;
        tick();                                  // N+1
        tick();                                  // N+2
        start = 1'b1;
        value = 9'd12;
        tick();                                  // N+3
        chk("ign busy@N+3", {8'b0, busy}, 9'd1);
        start = 1'b0;
        for (int i = 4; i <= 8; i++) tick();
        start = 1'b1;
        value = 9'd12;
        tick();                                  // N+9
        chk("ign done", {8'b0, done}, 9'd1);
        chk("ign bcd", bcd_out, 9'h045);
        chk("ign sign", {8'b0, sign_out}, 9'd0);
        tick();                                  // N+10, still in DONE at edge
        chk("ign busy@N+10", {8'b0, busy}, 9'd0);
        chk("ign done@N+10", {8'b0, done}, 9'd0);
        last_bcd  = 9'h045;
        last_sign = 1'b0;
        run("held12", 9'd12, 9'h012, 1'b0);      // start still high: edge N+11

        // reset mid-conversion
        start = 1'b1;
        value = 9'd88;
        tick();                                  // edge N
        start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        chk("rst pre busy", {8'b0, busy}, 9'd1);
        @(posedge clk);                          // edge N+5
        nrst = 1'b0;
        #1;
        chk("rst busy", {8'b0, busy}, 9'd0);
        chk("rst done", {8'b0, done}, 9'd0);
        chk("rst bcd", bcd_out, 9'h000);
        chk("rst sign", {8'b0, sign_out}, 9'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst no done", {8'b0, done}, 9'd0);
        end
        nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post rst idle", {8'b0, busy | done}, 9'd0);
        end
        last_bcd  = 9'h000;
        last_sign = 1'b0;
        run("v7", 9'd7, 9'h007, 1'b0);

        // back-to-back: -8 right on the first IDLE edge after 45
        run("b2b45", 9'd45, 9'h045, 1'b0);
        run("b2bm8", 9'h1F8, 9'h008, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
